// File: rtl/gray_conv_pkg.sv
// Shared types and defaults for the gray-code conversion arbiter.
package gray_conv_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    CONV = 2'd2
  } state_e;

endpackage

// File: rtl/gray_decode_stage.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all gray bits at or above it.
module gray_decode_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  always_comb begin
    binary = '0;
    for (int k = 0; k < WIDTH; k++) begin
      binary[k] = ^(gray >> k);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a shared gray-to-binary converter with a one-entry output hold.
// Optional macro GRAY_CONV_PIPE_EN inserts a register between capture and conversion (CONV state).
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_gray,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_binary,
  output logic [$clog2(NREQ)-1:0]  out_id
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [WIDTH-1:0] out_binary_q, out_binary_d;

  logic             found_hi, found_lo, grant_found, accept;
  logic [IDW-1:0]   hi_id, lo_id, grant_id, rr_next;
  logic [WIDTH-1:0] hi_gray, lo_gray, grant_gray;
  logic [WIDTH-1:0] dec_in, dec_out;

  // Two-pass search: first valid at or above rr_ptr, else first valid from index 0 (the wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_gray  = '0;
    lo_gray  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_hi && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found_hi = 1'b1;
        hi_id    = IDW'(i);
        hi_gray  = req_gray[i*WIDTH +: WIDTH];
      end
      if (!found_lo && req_valid[i]) begin
        found_lo = 1'b1;
        lo_id    = IDW'(i);
        lo_gray  = req_gray[i*WIDTH +: WIDTH];
      end
    end
    grant_found = found_hi | found_lo;
    grant_id    = found_hi ? hi_id : lo_id;
    grant_gray  = found_hi ? hi_gray : lo_gray;
    rr_next     = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
  end

  // Reset gating keeps req_ready low while rst_n is held, even though state reads IDLE.
  assign accept    = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign req_ready = (accept && grant_found) ? (NREQ'(1) << grant_id) : '0;

  gray_decode_stage #(.WIDTH(WIDTH)) u_decode (
    .gray   (dec_in),
    .binary (dec_out)
  );

`ifdef GRAY_CONV_PIPE_EN
  logic [WIDTH-1:0] conv_gray_q, conv_gray_d;
  logic [IDW-1:0]   conv_id_q, conv_id_d;

  assign dec_in = conv_gray_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_id_d     = out_id_q;
    out_binary_d = out_binary_q;
    conv_gray_d  = conv_gray_q;
    conv_id_d    = conv_id_q;
    if (state_q == CONV) begin
      state_d      = HOLD;
      out_binary_d = dec_out;
      out_id_d     = conv_id_q;
    end else if (accept) begin
      if (grant_found) begin
        state_d     = CONV;
        conv_gray_d = grant_gray;
        conv_id_d   = grant_id;
        rr_ptr_d    = rr_next;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_gray_q <= '0;
      conv_id_q   <= '0;
    end else begin
      conv_gray_q <= conv_gray_d;
      conv_id_q   <= conv_id_d;
    end
  end
`else
  assign dec_in = grant_gray;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_id_d     = out_id_q;
    out_binary_d = out_binary_q;
    if (accept) begin
      if (grant_found) begin
        state_d      = HOLD;
        out_binary_d = dec_out;
        out_id_d     = grant_id;
        rr_ptr_d     = rr_next;
      end else begin
        state_d = IDLE;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      out_id_q     <= '0;
      out_binary_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_id_q     <= out_id_d;
      out_binary_q <= out_binary_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_gray_conv_arbiter;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef GRAY_CONV_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_gray = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_binary;
  logic [IW-1:0]   out_id;

  int checks = 0;
  int errors = 0;

  // model state
  int            m_rr;
  bit            m_held, m_inf, m_acc;
  logic [W-1:0]  m_bin, m_inf_bin, m_gin;
  logic [IW-1:0] m_id, m_inf_id;

  // expectations for the current cycle
  logic [N-1:0]  exp_rdy;
  logic          exp_valid;
  logic [W-1:0]  exp_bin;
  logic [IW-1:0] exp_id;
  int            exp_grant;

  logic [N+W+IW:0] obs_v, exp_v;

  gray_conv_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_held = 0; m_inf = 0; m_bin = '0; m_id = '0;
    m_inf_bin = '0; m_inf_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic sample();
    @(negedge clk);
    exp_valid = m_held;
    exp_bin   = m_bin;
    exp_id    = m_id;
    m_acc     = !m_inf && (!m_held || out_ready);
    exp_grant = -1;
    if (m_acc) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (exp_grant < 0 && req_valid[i]) exp_grant = i;
      end
    end
    exp_rdy = '0;
    if (exp_grant >= 0) begin
      exp_rdy[exp_grant] = 1'b1;
      m_gin = req_gray[exp_grant*W +: W];
    end
    obs_v = {req_ready, out_valid, exp_valid ? {out_binary, out_id} : {(W+IW){1'b0}}};
    exp_v = {exp_rdy, exp_valid, exp_valid ? {exp_bin, exp_id} : {(W+IW){1'b0}}};
  endtask

  task automatic advance();
`ifdef GRAY_CONV_PIPE_EN
    if (m_inf) begin
      m_held = 1; m_bin = m_inf_bin; m_id = m_inf_id; m_inf = 0;
    end else if (m_acc) begin
      m_held = 0;
      if (exp_grant >= 0) begin
        m_inf = 1; m_inf_bin = g2b(m_gin); m_inf_id = IW'(exp_grant);
        m_rr = (exp_grant + 1) % N;
      end
    end
`else
    if (m_acc) begin
      m_held = (exp_grant >= 0);
      if (exp_grant >= 0) begin
        m_bin = g2b(m_gin); m_id = IW'(exp_grant);
        m_rr = (exp_grant + 1) % N;
      end
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req_valid = '1;
    req_gray  = 16'hF630;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_binary !== 4'b0000 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b bin=%b id=%0d want 0000/0/0000/0",
               req_ready, out_valid, out_binary, out_id);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 4'b1110;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_first_grant got %b want 0010", req_ready);
    end
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_model got %h want %h", obs_v, exp_v);
    end
    advance();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_drain c=%0d got %h want %h", c, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_gray  = {12'($urandom), 4'b0111};
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b want 0001", req_ready);
    end
    advance();
    req_valid = '0;
    for (int c = 1; c <= LAT + 1; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single_model c=%0d got %h want %h", c, obs_v, exp_v);
      end
      if (c == LAT) begin
        checks++;
        if (out_valid !== 1'b1 || out_binary !== 4'b0101 || out_id !== 2'd0) begin
          errors++;
          $display("FAIL single_result got vld=%b bin=%b id=%0d want 1/0101/0",
                   out_valid, out_binary, out_id);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want_out [4];
    want_out = '{4'b0000, 4'b0010, 4'b0100, 4'b1010};
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_gray  = 16'hF630;
    for (int c = 0; c < 6; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_model c=%0d got %h want %h", c, obs_v, exp_v);
      end
`ifndef GRAY_CONV_PIPE_EN
      checks++;
      if (req_ready !== (4'b0001 << (c % 4))) begin
        errors++;
        $display("FAIL b2b_grant c=%0d got %b want onehot %0d", c, req_ready, c % 4);
      end
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_binary !== want_out[(c-1)%4] || out_id !== IW'((c-1)%4)) begin
          errors++;
          $display("FAIL b2b_out c=%0d got %b id=%0d want %b id=%0d",
                   c, out_binary, out_id, want_out[(c-1)%4], (c-1)%4);
        end
      end
`endif
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_gray  = 16'h0040;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant got %b want 0010", req_ready);
    end
    advance();
    for (int c = 1; c <= LAT + 4; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL bp_model c=%0d got %h want %h", c, obs_v, exp_v);
      end
      if (c >= LAT) begin
        checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_binary !== 4'b0111 || out_id !== 2'd1) begin
          errors++;
          $display("FAIL bp_hold c=%0d got rdy=%b vld=%b bin=%b id=%0d want 0000/1/0111/1",
                   c, req_ready, out_valid, out_binary, out_id);
        end
      end
      advance();
    end
    out_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL bp_release c=%0d got %h want %h", c, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_fairness();
    int c0, c2;
    c0 = 0; c2 = 0;
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      req_gray = (N*W)'($urandom);
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL fair_model c=%0d got %h want %h", c, obs_v, exp_v);
      end
      if (req_ready[0]) c0++;
      if (req_ready[2]) c2++;
      advance();
    end
    checks++;
    if (c0 < 2 || c2 < 2 || c0 - c2 > 1 || c2 - c0 > 1) begin
      errors++;
      $display("FAIL fair_count got g0=%0d g2=%0d want balanced >=2 each", c0, c2);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_valid = N'($urandom);
      req_gray  = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d got %h want %h", c, obs_v, exp_v);
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b1000;
    req_gray  = 16'hF000;
    for (int c = 0; c <= LAT; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midrst_fill c=%0d got %h want %h", c, obs_v, exp_v);
      end
      advance();
      req_valid = '0;
    end
    checks++;
    if (out_valid !== 1'b1 || out_binary !== 4'b1010 || out_id !== 2'd3) begin
      errors++;
      $display("FAIL midrst_held got vld=%b bin=%b id=%0d want 1/1010/3", out_valid, out_binary, out_id);
    end
    req_valid = 4'b0110;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async got vld=%b rdy=%b want 0/0000", out_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_grant got %b want 0010", req_ready);
    end
    advance();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL midrst_after c=%0d got %h want %h", c, obs_v, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fairness();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits of every gray word and binary result.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the converter; legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester request strobe.
REQ-006 req_gray  input  NREQ*WIDTH  packed gray words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  NREQ  one-hot grant/accept pulse per requester.
REQ-008 out_valid  output  1  converted result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_binary  output  WIDTH  binary result, registered.
REQ-011 out_id  output  $clog2(NREQ)  index of the requester that produced out_binary.

Function
REQ-012 Conversion: out_binary[WIDTH-1] = gray[WIDTH-1]; out_binary[k] = out_binary[k+1] XOR gray[k] for k < WIDTH-1.
REQ-013 FSM states: IDLE (no result held) and HOLD (result held, out_valid=1).
REQ-014 Accept condition: state==IDLE, or state==HOLD with out_ready=1 in the same cycle (back-to-back, no bubble).
REQ-015 On accept with any req_valid high, grant exactly one requester, the first with req_valid=1 at or after rr_ptr (wrapping modulo NREQ).
REQ-016 Grant: req_ready[g]=1 combinationally in the accept cycle only; the requester's word is captured at that edge.
REQ-017 Latency: out_valid=1 with out_binary/out_id of the grant on the cycle after the grant (1 cycle).
REQ-018 After each grant, rr_ptr <= (g+1) mod NREQ; with no grant, rr_ptr holds.
REQ-019 HOLD with out_ready=0: out_valid, out_binary and out_id hold stable; all req_ready=0.
REQ-020 HOLD with out_ready=1 and no req_valid: go to IDLE, out_valid=0 next cycle.
REQ-021 IDLE with no req_valid: remain IDLE, req_ready all 0.
REQ-022 req_valid deasserted before grant is not an error; that requester is simply skipped.

Reset
REQ-023 While rst_n=0: state=IDLE, out_valid=0, out_binary=0, out_id=0, rr_ptr=0, req_ready all 0.
REQ-024 Reset asserted mid-operation discards any held or in-flight result; no output is produced for it after release.
REQ-025 First grant after reset release follows rr_ptr=0.

Configuration
REQ-026 Macro GRAY_CONV_PIPE_EN defined: a registered stage separates capture and conversion; latency grant->out_valid becomes 2 cycles; FSM adds state CONV between IDLE and HOLD; accept occurs only in IDLE, or in HOLD with out_ready=1 (throughput 1 result per 2 cycles minimum).
REQ-027 Macro undefined: single-stage behaviour of REQ-014..REQ-017 exactly; no CONV state.

Structure
REQ-028 Shared package gray_conv_pkg holds the state enum type (IDLE, HOLD, CONV) and default WIDTH/NREQ constants.
REQ-029 Combinational conversion lives in sub-module gray_decode_stage (WIDTH param, gray in, binary out); arbiter instantiates it once.

Verification
REQ-030 Single request: req_valid=4'b0001, req0 gray=0111 -> req_ready[0] pulse, next cycle out_valid=1, out_binary=0101, out_id=0.
REQ-031 All four valid continuously, gray words 0000/0011/0110/1111, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; outputs 0000,0010,0100,1010.
REQ-032 Backpressure: out_ready=0 for 5 cycles with req1 gray=0100 held -> out_binary=0111, out_id=1 stable, req_ready all 0 throughout.
REQ-033 Fairness: req0 and req2 always valid -> grants alternate 0,2,0,2; neither starved.
REQ-034 Reset mid-HOLD (out_binary=1010) -> out_valid=0 immediately, after release first grant goes to lowest valid index >=0.
REQ-035 GRAY_CONV_PIPE_EN build: repeat REQ-030 -> out_valid 2 cycles after grant, same values.
